ntt_stage_ctrl: RTL and testbench

NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

---
 rtl/ntt_pkg.sv | 14 +
 rtl/ntt_offset_calc.sv | 20 ++
 rtl/ntt_stage_ctrl.sv | 93 +++++++++
 tb/tb_ntt_stage_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the forward-NTT stage sequencer.
package ntt_pkg;
    localparam int N               = 256;
    localparam int NUM_CORES       = 8;
    localparam int ITERS_PER_STAGE = N / 2 / NUM_CORES;
    localparam int LEN_FIRST       = N / 2;
    localparam int LEN_LAST        = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/ntt_offset_calc.sv
// Per-core upper-operand offset; short stages interleave butterfly groups so
// the lower operand (offs_a+len) stays inside the core's 32-word window.
module ntt_offset_calc #(
    parameter int LEN_W = 8
) (
    input  logic [LEN_W-1:0] len,
    input  logic [3:0]       iter,
    output logic [4:0]       offs_a
);
    // Insert a zero bit at position log2(len) to skip over the lower half-group.
    always_comb begin
        offs_a = {1'b0, iter};
        case (len)
            LEN_W'(8): offs_a = {iter[3],   1'b0, iter[2:0]};
            LEN_W'(4): offs_a = {iter[3:2], 1'b0, iter[1:0]};
            LEN_W'(2): offs_a = {iter[3:1], 1'b0, iter[0]};
            default:   offs_a = {1'b0, iter};
        endcase
    end
endmodule

// File: rtl/ntt_stage_ctrl.sv
// Sequences the seven forward-NTT stages as (len, stage, iter) commands to the
// butterfly array with valid/ready flow control, abort and a done pulse.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter int ITERS = ITERS_PER_STAGE,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [LEN_W-1:0] len,
    output logic [2:0]       stage,
    output logic [3:0]       iter,
    output logic [4:0]       offs_a,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nx;
    logic [LEN_W-1:0] len_nx;
    logic [2:0]       stage_nx;
    logic [3:0]       iter_nx;
    logic             hs, last_iter, last_len;

    assign hs        = valid && ready;
    assign last_iter = (iter == 4'(ITERS - 1));
    assign last_len  = (len == LEN_W'(LEN_LAST));

    always_comb begin
        state_nx = state;
        len_nx   = len;
        stage_nx = stage;
        iter_nx  = iter;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = RUN;
                    len_nx   = LEN_W'(LEN_FIRST);
                    stage_nx = 3'd0;
                    iter_nx  = 4'd0;
                end
            end
            RUN: begin
                // abort outranks a handshake landing in the same cycle
                if (abort) begin
                    state_nx = IDLE;
                end else if (hs) begin
                    if (!last_iter) begin
                        iter_nx = iter + 4'd1;
                    end else if (!last_len) begin
                        iter_nx  = 4'd0;
                        len_nx   = len >> 1;
                        stage_nx = stage + 3'd1;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            len   <= LEN_W'(LEN_FIRST);
            stage <= 3'd0;
            iter  <= 4'd0;
        end else begin
            state <= state_nx;
            valid <= (state_nx == RUN);
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == FIN);
            len   <= len_nx;
            stage <= stage_nx;
            iter  <= iter_nx;
        end
    end

    ntt_offset_calc #(.LEN_W(LEN_W)) u_offs (
        .len    (len),
        .iter   (iter),
        .offs_a (offs_a)
    );
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: expected commands/done cycles are queued
// by the stimulus and consumed by a monitor on every handshake / done pulse.
module tb_ntt_stage_ctrl;
    logic       clk, rst_n, start, abort, ready;
    logic       valid, busy, done;
    logic [7:0] len;
    logic [2:0] stage;
    logic [3:0] iter;
    logic [4:0] offs_a;

    typedef struct {
        int l;
        int s;
        int it;
        int o;
    } cmd_t;

    cmd_t exp_q[$];
    int   done_q[$];
    int   tests, fails, hs_cnt, cyc;

    int tab4[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19, 24, 25, 26, 27};
    int tab2[16] = '{0, 1, 4, 5, 8, 9, 12, 13, 16, 17, 20, 21, 24, 25, 28, 29};

    ntt_stage_ctrl #(.ITERS(16), .LEN_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .ready  (ready),
        .valid  (valid),
        .len    (len),
        .stage  (stage),
        .iter   (iter),
        .offs_a (offs_a),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s", nm);
    endtask

    // Group the operands by half-block: offset = block*2*len + position in block.
    function automatic int offs_model(input int l, input int it);
        if (l >= 16) return it;
        return (it / l) * (2 * l) + (it % l);
    endfunction

    task automatic push_cmds(input int n);
        cmd_t c;
        for (int k = 0; k < n; k++) begin
            c.s  = k / 16;
            c.it = k % 16;
            c.l  = 128 >> c.s;
            c.o  = offs_model(c.l, c.it);
            exp_q.push_back(c);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_run(output int n0);
        start = 1'b1;
        n0    = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (done_q.size() != 0) begin
            fail_now("done_timeout");
            done_q.delete();
        end
    endtask

    // Monitor: consume one expected command per handshake, one done per pulse.
    always @(negedge clk) begin : monitor
        cmd_t e;
        int   d;
        if (rst_n) begin
            if (valid && ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_cmd");
                end else begin
                    e = exp_q.pop_front();
                    chk("len",    int'(len),    e.l);
                    chk("stage",  int'(stage),  e.s);
                    chk("iter",   int'(iter),   e.it);
                    chk("offs_a", int'(offs_a), e.o);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle",    cyc,        d);
                    chk("busy_at_done",  int'(busy),  1);
                    chk("valid_at_done", int'(valid), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        cyc = 0; tests = 0; fails = 0; hs_cnt = 0;

        #12;
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_len",   int'(len),   128);
        chk("rst_stage", int'(stage), 0);
        chk("rst_iter",  int'(iter),  0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ready = 1'b1;
        tick(2);
        chk("idle_ignores_ready", int'(valid), 0);

        // Full run with ready held high, plus short-stage offset tables.
        hs_cnt = 0;
        push_cmds(112);
        start_run(n0);
        done_q.push_back(n0 + 113);
        chk("first_valid", int'(valid), 1);
        chk("first_busy",  int'(busy),  1);
        tick(80);
        for (int i = 0; i < 16; i++) begin
            chk("len4_len",  int'(len),    4);
            chk("len4_offs", int'(offs_a), tab4[i]);
            if (i == 15) chk("len4_top", int'(offs_a) + int'(len), 31);
            tick(1);
        end
        for (int i = 0; i < 16; i++) begin
            chk("len2_len",  int'(len),    2);
            chk("len2_offs", int'(offs_a), tab2[i]);
            tick(1);
        end
        wait_done(20);
        chk("busy_after_done", int'(busy), 0);
        chk("run1_handshakes", hs_cnt, 112);
        chk("run1_queue_empty", exp_q.size(), 0);

        // Backpressure at len=32 iter=7; this start lands right after FIN.
        push_cmds(112);
        start_run(n0);
        done_q.push_back(n0 + 113 + 5);
        tick(39);
        ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("bp_valid", int'(valid), 1);
            chk("bp_len",   int'(len),   32);
            chk("bp_stage", int'(stage), 2);
            chk("bp_iter",  int'(iter),  7);
            tick(1);
        end
        ready = 1'b1;
        tick(1);
        chk("bp_next_iter", int'(iter), 8);
        chk("bp_next_len",  int'(len),  32);
        wait_done(200);

        // start and abort together in IDLE: stay idle.
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        chk("sa_valid", int'(valid), 0);
        chk("sa_busy",  int'(busy),  0);
        tick(1);
        chk("sa_valid2", int'(valid), 0);

        // Abort at len=16 iter=3 with ready high.
        push_cmds(52);
        start_run(n0);
        tick(51);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_valid", int'(valid), 0);
        chk("abort_busy",  int'(busy),  0);
        chk("abort_done",  int'(done),  0);
        tick(3);
        chk("abort_queue_empty", exp_q.size(), 0);

        // Restart after abort, with a stray start while busy at stage 3.
        hs_cnt = 0;
        push_cmds(112);
        start_run(n0);
        done_q.push_back(n0 + 113);
        chk("restart_len",  int'(len),  128);
        chk("restart_iter", int'(iter), 0);
        tick(50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(200);
        chk("busy_start_handshakes", hs_cnt, 112);

        // Reset mid-run at stage 5, between clock edges.
        push_cmds(86);
        start_run(n0);
        tick(85);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(valid), 0);
        chk("arst_len",   int'(len),   128);
        chk("arst_busy",  int'(busy),  0);
        chk("arst_stage", int'(stage), 0);
        chk("arst_iter",  int'(iter),  0);
        chk("arst_done",  int'(done),  0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_valid", int'(valid), 0);
        chk("post_rst_busy",  int'(busy),  0);
        chk("final_cmd_queue",  exp_q.size(),  0);
        chk("final_done_queue", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
